// File: rtl/pixel_frame_store.sv
// Pixel locator and bit-packed frame store for the shape recogniser.
// Tracks the (x,y) position of the pixel on the incoming VGA stream and
// provides a simple dual-port RAM of 8-pixel words (1-cycle read latency).
module pixel_frame_store #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        iVGA_HS,
    input  logic        iVGA_VS,
    input  logic        iVGA_BLANK_N,
    output logic [12:0] x_count,
    output logic [12:0] y_count,
    input  logic [7:0]  data,
    input  logic [15:0] wraddress,
    input  logic        wren,
    input  logic [15:0] rdaddress,
    output logic [7:0]  q
);
    localparam int          DEPTH   = WIDTH * HEIGHT / 8;
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so a 65536-word store still compares correctly.
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    logic       prev_blank_n;
    logic       wr_ok;
    logic       rd_ok;
    logic [7:0] mem [DEPTH];

    // Out-of-range addresses never touch the array.
    assign wr_ok = wren && ({1'b0, wraddress} < DEPTH_W);
    assign rd_ok = {1'b0, rdaddress} < DEPTH_W;

    // Column counter: cleared by HS, advances on each active pixel.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset)
            x_count <= '0;
        else if (!iVGA_HS)
            x_count <= '0;
        else if (iVGA_BLANK_N)
            x_count <= x_count + 13'd1;
    end

    // Row counter: cleared by VS, advances on the falling edge of BLANK_N.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            y_count      <= '0;
            prev_blank_n <= 1'b0;
        end else begin
            prev_blank_n <= iVGA_BLANK_N;
            if (!iVGA_VS)
                y_count <= '0;
            else if (prev_blank_n && !iVGA_BLANK_N)
                y_count <= y_count + 13'd1;
        end
    end

    // Write port; contents survive reset.
    always_ff @(posedge VGA_CLK) begin
        if (wr_ok)
            mem[wraddress[AW-1:0]] <= data;
    end

    // Registered read; a same-address write in this cycle is not yet visible,
    // so the old word is returned.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset)
            q <= '0;
        else if (rd_ok)
            q <= mem[rdaddress[AW-1:0]];
        else
            q <= '0;
    end
endmodule

// File: tb/tb_pixel_frame_store.sv
// Self-checking bench for pixel_frame_store: RAM vector table, randomized
// RAM traffic against an array model, a full frame of 640x480-style timing
// scaled to 480x16, and an asynchronous mid-line reset.
module tb_pixel_frame_store;
    localparam int W     = 480;
    localparam int H     = 16;
    localparam int DEPTH = W * H / 8;
    localparam int HTOT  = W + 160;   // active, front 16, sync 96, back 48
    localparam int VTOT  = H + 45;    // active, front 10, sync 2, back 33

    logic        VGA_CLK = 1'b0;
    logic        reset;
    logic        iVGA_HS, iVGA_VS, iVGA_BLANK_N;
    logic [12:0] x_count, y_count;
    logic [7:0]  data;
    logic [15:0] wraddress, rdaddress;
    logic        wren;
    logic [7:0]  q;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mm [1024];
    bit         mv [1024];
    int         hpos = 0;
    int         vpos = 0;

    typedef struct {
        logic        w;
        logic [15:0] wa;
        logic [7:0]  d;
        logic [15:0] ra;
        bit          chk;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl[$];

    pixel_frame_store #(.WIDTH(W), .HEIGHT(H)) dut (
        .VGA_CLK(VGA_CLK), .reset(reset),
        .iVGA_HS(iVGA_HS), .iVGA_VS(iVGA_VS), .iVGA_BLANK_N(iVGA_BLANK_N),
        .x_count(x_count), .y_count(y_count),
        .data(data), .wraddress(wraddress), .wren(wren),
        .rdaddress(rdaddress), .q(q)
    );

    always #20 VGA_CLK = ~VGA_CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One RAM cycle: drive after a negedge, let the posedge act, compare q at
    // the next negedge. Expected q comes from the model before this write.
    task automatic ram_step(input logic w, input logic [15:0] wa, input logic [7:0] d,
                            input logic [15:0] ra, input bit chk, input logic [7:0] exp,
                            input string nm);
        wren = w; wraddress = wa; data = d; rdaddress = ra;
        @(negedge VGA_CLK);
        if (chk) check(nm, {24'd0, q}, {24'd0, exp});
        if (w && wa < 16'(DEPTH)) begin
            mm[wa[9:0]] = d;
            mv[wa[9:0]] = 1'b1;
        end
    endtask

    // Video steps: each drives the pixel at (hpos,vpos) and compares the
    // position outputs against the pixel's place in the frame.
    task automatic run_video(input int n, input bit cx, input bit cy);
        for (int i = 0; i < n; i++) begin
            iVGA_BLANK_N = (hpos < W) && (vpos < H);
            iVGA_HS      = !(hpos >= W + 16 && hpos < W + 112);
            iVGA_VS      = !(vpos >= H + 10 && vpos < H + 12);
            #1;
            if (cx) begin
                int ex;
                if (vpos < H && hpos < W)       ex = hpos;
                else if (vpos < H && hpos <= W + 16) ex = W;
                else                            ex = 0;
                check($sformatf("x_count@%0d,%0d", vpos, hpos), {19'd0, x_count}, ex);
            end
            if (cy) begin
                int ey;
                if (vpos < H)                             ey = (hpos > W) ? vpos + 1 : vpos;
                else if (vpos < H + 10)                   ey = H;
                else if (vpos == H + 10 && hpos == 0)     ey = H;
                else                                      ey = 0;
                check($sformatf("y_count@%0d,%0d", vpos, hpos), {19'd0, y_count}, ey);
            end
            @(negedge VGA_CLK);
            hpos++;
            if (hpos == HTOT) begin
                hpos = 0;
                vpos = (vpos + 1) % VTOT;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
        reset = 1'b1;
        iVGA_HS = 1'b1; iVGA_VS = 1'b1; iVGA_BLANK_N = 1'b0;
        wren = 1'b0; wraddress = '0; data = '0; rdaddress = '0;
        repeat (3) @(negedge VGA_CLK);
        check("reset x_count", {19'd0, x_count}, 0);
        check("reset y_count", {19'd0, y_count}, 0);
        check("reset q", {24'd0, q}, 0);
        reset = 1'b0;
        @(negedge VGA_CLK);

        // Directed RAM vectors.
        tbl.push_back('{1'b1, 16'h0050, 8'hA5, 16'h0000, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 16'h0000, 8'h00, 16'h0050, 1'b1, 8'hA5});
        tbl.push_back('{1'b1, 16'h0007, 8'h3C, 16'h0050, 1'b1, 8'hA5});
        tbl.push_back('{1'b1, 16'h0007, 8'hC3, 16'h0007, 1'b1, 8'h3C});
        tbl.push_back('{1'b0, 16'h0000, 8'h00, 16'h0007, 1'b1, 8'hC3});
        tbl.push_back('{1'b1, 16'hFFFF, 8'h5A, 16'hFFFF, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 16'h0407, 8'h11, 16'hFFFF, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 16'h0000, 8'h00, 16'h0007, 1'b1, 8'hC3});
        tbl.push_back('{1'b1, 16'h03BF, 8'h77, 16'h03C0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 16'h0003, 8'h96, 16'h03BF, 1'b1, 8'h77});
        tbl.push_back('{1'b0, 16'h0000, 8'h00, 16'h0003, 1'b1, 8'h96});
        tbl.push_back('{1'b0, 16'h0000, 8'h00, 16'h0050, 1'b1, 8'hA5});
        foreach (tbl[i])
            ram_step(tbl[i].w, tbl[i].wa, tbl[i].d, tbl[i].ra, tbl[i].chk, tbl[i].exp,
                     $sformatf("ram_vec%0d", i));

        // Randomized RAM traffic: small address pool for collisions plus
        // addresses straddling the end of the store.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] wa, ra;
            logic [7:0]  d, e;
            logic        w;
            bit          c;
            wa = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(940, 1100)) : 16'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(940, 1100)) : 16'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) ra = 16'hFFFF;
            d  = 8'($urandom);
            w  = 1'($urandom);
            if (ra >= 16'(DEPTH)) begin c = 1'b1; e = 8'h00; end
            else begin c = mv[ra[9:0]]; e = mm[ra[9:0]]; end
            ram_step(w, wa, d, ra, c, e, $sformatf("ram_rand%0d@%0h", i, ra));
        end

        // Park the read port on a known word and run a frame plus two lines.
        wren = 1'b0;
        rdaddress = 16'h0050;
        run_video(VTOT * HTOT + 2 * HTOT + 200, 1'b1, 1'b1);

        // Asynchronous reset between edges, mid-line.
        check("q before reset", {24'd0, q}, 32'hA5);
        #5 reset = 1'b1;
        #1;
        check("async reset x_count", {19'd0, x_count}, 0);
        check("async reset y_count", {19'd0, y_count}, 0);
        check("async reset q", {24'd0, q}, 0);
        @(negedge VGA_CLK);
        run_video(3, 1'b0, 1'b0);
        reset = 1'b0;
        run_video(HTOT - hpos, 1'b0, 1'b0);
        run_video(HTOT, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
